// File: rtl/ysyx_220053_pkg.sv
// Shared definitions for the IDU stage: RV64I opcodes, format codes and the decoded entry.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ysyx_220053_pkg;

  // Major opcodes (instr[6:0]); anything outside this set is illegal.
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Instruction format codes as presented on out_fmt.
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // The only two legal SYSTEM encodings.
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  // Decoded entry. pc/imm are held at the widest supported XLEN (64); the
  // stage truncates to its own XLEN at the output. Sign-extending to 64 and
  // truncating to 32 equals sign-extending to 32 directly.
  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [6:0]  op;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        wen;
    logic        illegal;
    logic        ebreak;
  } dec_entry_t;

  // Immediate generator: sign-extended immediate for the given format, 0 for R.
  function automatic logic [63:0] gen_imm(input logic [31:0] ins, input logic [2:0] fmt);
    gen_imm = '0;
    case (fmt)
      FMT_I:   gen_imm = {{52{ins[31]}}, ins[31:20]};
      FMT_S:   gen_imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   gen_imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   gen_imm = {{32{ins[31]}}, ins[31:12], 12'b0};
      FMT_J:   gen_imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: gen_imm = '0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_220053_dec_comb.sv
// Purely combinational RV64I decoder: {pc, instr} -> dec_entry_t.
// Latency: 0 cycles (no state).
// Backpressure: none; the enclosing stage decides when the result is captured.
// Ports: pc_i (64-bit, zero-extended by caller), instr_i (raw word), dec_o (decoded entry).
module ysyx_220053_dec_comb
  import ysyx_220053_pkg::*;
(
  input  logic [63:0] pc_i,
  input  logic [31:0] instr_i,
  output dec_entry_t  dec_o
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rd;
  logic [2:0] fmt;
  logic       wen_raw;
  logic       illegal;
  logic       is_ebreak;

  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign rd = instr_i[11:7];

  always_comb begin
    fmt       = FMT_R;
    wen_raw   = 1'b0;
    illegal   = 1'b0;
    is_ebreak = 1'b0;
    case (op)
      OP_LUI:    begin fmt = FMT_U; wen_raw = 1'b1; end
      OP_AUIPC:  begin fmt = FMT_U; wen_raw = 1'b1; end
      OP_JAL:    begin fmt = FMT_J; wen_raw = 1'b1; end
      OP_JALR:   begin fmt = FMT_I; wen_raw = 1'b1; illegal = (f3 != 3'b000); end
      OP_BRANCH: begin fmt = FMT_B; illegal = (f3 == 3'b010) || (f3 == 3'b011); end
      OP_LOAD:   begin fmt = FMT_I; wen_raw = 1'b1; illegal = (f3 == 3'b111); end
      OP_STORE:  begin fmt = FMT_S; illegal = f3[2]; end
      OP_IMM:    begin fmt = FMT_I; wen_raw = 1'b1; end
      OP_IMM32: begin
        fmt     = FMT_I;
        wen_raw = 1'b1;
        // Only ADDIW / SLLIW / SRLIW-SRAIW exist in the 32-bit immediate group.
        illegal = !((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101));
      end
      OP_OP:     begin fmt = FMT_R; wen_raw = 1'b1; end
      OP_OP32:   begin fmt = FMT_R; wen_raw = 1'b1; end
      OP_SYSTEM: begin
        fmt       = FMT_I;
        illegal   = (instr_i != INSTR_ECALL) && (instr_i != INSTR_EBREAK);
        is_ebreak = (instr_i == INSTR_EBREAK);
      end
      default:   illegal = 1'b1;
    endcase
    // Compressed / non-32-bit encodings; redundant with the opcode map today but
    // kept explicit so the map can grow without reopening this hole.
    if (instr_i[1:0] != 2'b11) begin
      illegal   = 1'b1;
      is_ebreak = 1'b0;
    end
  end

  always_comb begin
    dec_o         = '0;
    dec_o.pc      = pc_i;
    dec_o.rd      = rd;
    dec_o.rs1     = instr_i[19:15];
    dec_o.rs2     = instr_i[24:20];
    dec_o.func3   = f3;
    dec_o.func7   = instr_i[31:25];
    dec_o.op      = op;
    dec_o.imm     = gen_imm(instr_i, fmt);
    dec_o.fmt     = fmt;
    // x0 writes are dropped here so EXU never has to special-case them.
    dec_o.wen     = wen_raw && !illegal && (rd != 5'd0);
    dec_o.illegal = illegal;
    dec_o.ebreak  = is_ebreak;
  end

endmodule

// File: rtl/ysyx_220053_idu_stage.sv
// Registered RV64I decode stage between IFU and EXU with optional 2-entry skid buffer.
// Latency: 1 cycle from accept to out_valid; trap_ebreak pulses the cycle after an ebreak retires.
// Backpressure: SKID=1 -> in_ready registered (occupancy<2); SKID=0 -> in_ready = !out_valid || out_ready.
// Ports: clk/rst_n; flush; in_valid/in_ready/in_pc/in_instr (IFU side);
//        out_valid/out_ready plus decoded fields out_* (EXU side); trap_ebreak; illegal_cnt.
module ysyx_220053_idu_stage
  import ysyx_220053_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_func3,
  output logic [6:0]       out_func7,
  output logic [6:0]       out_op,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_wen,
  output logic             out_illegal,
  output logic             trap_ebreak,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [63:0] pc_ext;
  dec_entry_t  dec;

  dec_entry_t       head_q;   // entry presented on out_*
  dec_entry_t       tail_q;   // second slot, only populated when SKID=1
  logic [1:0]       occ_q, occ_d;
  logic             rdy_q;
  logic             trap_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept;
  logic retire;

  always_comb begin
    pc_ext             = '0;
    pc_ext[XLEN-1:0]   = in_pc;
  end

  ysyx_220053_dec_comb u_dec (
    .pc_i    (pc_ext),
    .instr_i (in_instr),
    .dec_o   (dec)
  );

  assign out_valid = (occ_q != 2'd0);
  assign retire    = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

  // flush gates in_ready, so a same-cycle input is never accepted.
  always_comb begin
    if (SKID != 0) in_ready = rdy_q && !flush;
    else           in_ready = (!out_valid || out_ready) && !flush;
  end

  always_comb begin
    occ_d = occ_q;
    if (flush)                 occ_d = 2'd0;
    else if (accept && !retire) occ_d = occ_q + 2'd1;
    else if (!accept && retire) occ_d = occ_q - 2'd1;
  end

  // Occupancy and the registered ready. rdy_q is computed from next-state
  // occupancy so in_ready never looks at out_ready in the skid configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= 2'd0;
      rdy_q <= 1'b1;
    end else begin
      occ_q <= occ_d;
      rdy_q <= (occ_d != 2'd2);
    end
  end

  // Entry storage. Accept+retire only happens with one entry held (ready is
  // low at two), so the new entry lands directly in the head slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (!flush) begin
      if (accept && ((occ_q == 2'd0) || retire)) head_q <= dec;
      else if (retire)                            head_q <= tail_q;
      if (accept && (occ_q == 2'd1) && !retire)   tail_q <= dec;
    end
  end

  // Trap pulse and illegal counter follow the downstream handshake only;
  // flush neither cancels a pending pulse nor touches the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      trap_q <= retire && head_q.ebreak;
      if (retire && head_q.illegal && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_pc      = head_q.pc[XLEN-1:0];
  assign out_rd      = head_q.rd;
  assign out_rs1     = head_q.rs1;
  assign out_rs2     = head_q.rs2;
  assign out_func3   = head_q.func3;
  assign out_func7   = head_q.func7;
  assign out_op      = head_q.op;
  assign out_imm     = head_q.imm[XLEN-1:0];
  assign out_fmt     = head_q.fmt;
  assign out_wen     = head_q.wen;
  assign out_illegal = head_q.illegal;
  assign trap_ebreak = trap_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_220053_idu_stage.sv
// Scoreboard bench for ysyx_220053_idu_stage (XLEN=64, SKID=1, CNT_W=2).
// Stimulus pushes hand-computed expectations on accept; a negedge monitor pops on handshake.
// Monitor also tracks expected illegal_cnt / trap_ebreak from retired entries.
module tb_ysyx_220053_idu_stage;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        wen, ill, ebr, dc;  // dc: fmt/imm unspecified (unknown opcode)
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [31:0] in_instr;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_func3, out_fmt;
  logic [6:0]  out_func7, out_op;
  logic        out_wen, out_illegal, trap_ebreak;
  logic [1:0]  illegal_cnt;

  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];
  exp_t mon_e;
  int   exp_cnt = 0;
  logic exp_trap = 1'b0;

  always #5 clk = ~clk;

  ysyx_220053_idu_stage #(.XLEN(64), .SKID(1), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_func3(out_func3), .out_func7(out_func7), .out_op(out_op),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_wen(out_wen), .out_illegal(out_illegal),
    .trap_ebreak(trap_ebreak), .illegal_cnt(illegal_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] pc, input logic [4:0] rd, rs1, rs2,
                              input logic [2:0] f3, input logic [6:0] f7, op,
                              input logic [63:0] imm, input logic [2:0] fmt,
                              input logic wen, ill, ebr, dc);
    exp_t e;
    e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.f7 = f7; e.op = op;
    e.imm = imm; e.fmt = fmt; e.wen = wen; e.ill = ill; e.ebr = ebr; e.dc = dc;
    return e;
  endfunction

  // Called just after a posedge; returns just after the posedge that accepted.
  task automatic send(input logic [31:0] instr, input exp_t e);
    bit done = 0;
    in_pc = e.pc; in_instr = instr; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !out_valid) return;
    end
    chk("drain_timeout", 64'(sbq.size()), 64'd0);
  endtask

  // Monitor: checks counter/trap model every cycle, pops on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_cnt  = 0;
      exp_trap = 1'b0;
    end else begin
      chk("illegal_cnt", 64'(illegal_cnt), 64'(exp_cnt));
      chk("trap_ebreak", 64'(trap_ebreak), 64'(exp_trap));
      exp_trap = 1'b0;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("pc",      out_pc,      mon_e.pc);
          chk("rd",      out_rd,      mon_e.rd);
          chk("rs1",     out_rs1,     mon_e.rs1);
          chk("rs2",     out_rs2,     mon_e.rs2);
          chk("func3",   out_func3,   mon_e.f3);
          chk("func7",   out_func7,   mon_e.f7);
          chk("op",      out_op,      mon_e.op);
          chk("wen",     out_wen,     mon_e.wen);
          chk("illegal", out_illegal, mon_e.ill);
          if (!mon_e.dc) begin
            chk("imm", out_imm, mon_e.imm);
            chk("fmt", out_fmt, mon_e.fmt);
          end
          if (mon_e.ill && exp_cnt != 3) exp_cnt++;
          exp_trap = mon_e.ebr;
        end
      end
    end
  end

  initial begin
    #200000;
    chk("watchdog", 64'd0, 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_trap", trap_ebreak, 0);
    chk("rst_cnt", illegal_cnt, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Decode patterns, streaming with out_ready high.
    @(posedge clk); #1 out_ready = 1'b1;
    send(32'h0050_0093, mk(64'h8000_0000, 1, 0, 5, 0, 7'h00, 7'h13, 64'd5, 1, 1, 0, 0, 0));
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    @(posedge clk); #1;
    send(32'hFE20_AE23, mk(64'h8000_0004, 28, 1, 2, 2, 7'h7F, 7'h23, 64'hFFFF_FFFF_FFFF_FFFC, 2, 0, 0, 0, 0));
    send(32'h1234_52B7, mk(64'h8000_0008, 5, 8, 3, 5, 7'h09, 7'h37, 64'h0000_0000_1234_5000, 4, 1, 0, 0, 0));
    send(32'h0080_006F, mk(64'h8000_000C, 0, 0, 8, 0, 7'h00, 7'h6F, 64'd8, 5, 0, 0, 0, 0));
    send(32'hFE20_8CE3, mk(64'h8000_0010, 25, 1, 2, 0, 7'h7F, 7'h63, 64'hFFFF_FFFF_FFFF_FFF8, 3, 0, 0, 0, 0));
    send(32'h0101_3183, mk(64'h8000_0014, 3, 2, 16, 3, 7'h00, 7'h03, 64'd16, 1, 1, 0, 0, 0));
    send(32'h0073_02B3, mk(64'h8000_0018, 5, 6, 7, 0, 7'h00, 7'h33, 64'd0, 0, 1, 0, 0, 0));
    send(32'h8000_0517, mk(64'h8000_001C, 10, 0, 0, 0, 7'h40, 7'h17, 64'hFFFF_FFFF_8000_0000, 4, 1, 0, 0, 0));
    send(32'h0000_2063, mk(64'h8000_0020, 0, 0, 0, 2, 7'h00, 7'h63, 64'd0, 3, 0, 1, 0, 0));
    send(32'h0000_201B, mk(64'h8000_0024, 0, 0, 0, 2, 7'h00, 7'h1B, 64'd0, 1, 0, 1, 0, 0));
    send(32'h0000_0073, mk(64'h8000_0028, 0, 0, 0, 0, 7'h00, 7'h73, 64'd0, 1, 0, 0, 0, 0));
    send(32'h0020_0073, mk(64'h8000_002C, 0, 0, 2, 0, 7'h00, 7'h73, 64'd2, 1, 0, 1, 0, 0));
    wait_empty();

    // Skid: two accepts fill the buffer, third waits for drain.
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'hFE20_8CE3, mk(64'h8000_0100, 25, 1, 2, 0, 7'h7F, 7'h63, 64'hFFFF_FFFF_FFFF_FFF8, 3, 0, 0, 0, 0));
    send(32'h0101_3183, mk(64'h8000_0104, 3, 2, 16, 3, 7'h00, 7'h03, 64'd16, 1, 1, 0, 0, 0));
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("stall_pc_a", out_pc, 64'h8000_0100);
    @(negedge clk);
    chk("stall_pc_b", out_pc, 64'h8000_0100);
    @(posedge clk); #1;
    fork
      send(32'h0073_02B3, mk(64'h8000_0108, 5, 6, 7, 0, 7'h00, 7'h33, 64'd0, 0, 1, 0, 0, 0));
      begin repeat (3) @(posedge clk); #1 out_ready = 1'b1; end
    join
    wait_empty();

    // ebreak held, then retired: single pulse on the following cycle.
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'h0010_0073, mk(64'h8000_0200, 0, 0, 1, 0, 7'h00, 7'h73, 64'd1, 1, 0, 0, 1, 0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ebreak_hold_trap", trap_ebreak, 0);
      chk("ebreak_hold_valid", out_valid, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); chk("trap_before", trap_ebreak, 0);
    @(negedge clk); chk("trap_pulse", trap_ebreak, 1);
    @(negedge clk); chk("trap_after", trap_ebreak, 0);
    wait_empty();

    // Flush with two buffered entries and a same-cycle input.
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'hFFFF_FFFF, mk(64'h8000_0300, 31, 31, 31, 7, 7'h7F, 7'h7F, 64'd0, 0, 0, 1, 0, 1));
    send(32'h0050_0093, mk(64'h8000_0304, 1, 0, 5, 0, 7'h00, 7'h13, 64'd5, 1, 1, 0, 0, 0));
    flush = 1'b1; in_valid = 1'b1; in_pc = 64'h8000_0308; in_instr = 32'h1234_52B7;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_ready_back", in_ready, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_nothing", out_valid, 0);
    end

    // Asynchronous reset with an entry buffered and a non-zero count.
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'h8000_0517, mk(64'h8000_0400, 10, 0, 0, 0, 7'h40, 7'h17, 64'hFFFF_FFFF_8000_0000, 4, 1, 0, 0, 0));
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_cnt", illegal_cnt, 0);
    chk("arst_out_pc", out_pc, 0);
    chk("arst_out_imm", out_imm, 0);
    chk("arst_out_rd", out_rd, 0);
    chk("arst_trap", trap_ebreak, 0);
    sbq.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Saturating counter: 1,2,3,3 tracked by the monitor model.
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send(32'hFFFF_FFFF, mk(64'h8000_0500 + 64'(4 * i), 31, 31, 31, 7, 7'h7F, 7'h7F, 64'd0, 0, 0, 1, 0, 1));
    wait_empty();
    @(negedge clk);
    chk("cnt_saturated", illegal_cnt, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
